// File: rtl/rv32i_decode_execute.sv
// rv32i_decode_execute
//   Combinational decode/execute slice of the single-cycle RV32I core:
//   main decoder (control signals), ALU and branch comparator. A single
//   register keeps a sticky record of any illegal opcode observed.
//
// Ports
//   sysclk, sysreset   clock and asynchronous active-high reset (sticky flag only)
//   inst               current instruction
//   a_in, b_in         ALU operands from the external A/B muxes
//   rs1, rs2           register operands for the branch comparator
//   alu_result         ALU output
//   brq                branch condition true (computed for every instruction)
//   pc_sel             0 = pc+4, 1 = alu_result
//   reg_we, mem_we     register-file / data-memory write enables
//   a_sel              0 = pc_curr, 1 = rs1
//   b_sel              0 = rs2,     1 = imm_x
//   inst_type          immediate format 0=R 1=I 2=S 3=B 4=U 5=J
//   alu_op             ALU operation code
//   funct3             inst[14:12] pass-through
//   wb_sel             00 alu, 01 load, 10 pc_next, 11 imm_x
//   illegal            unsupported opcode (combinational)
//   illegal_seen       sticky registered illegal flag
module rv32i_decode_execute #(
  parameter int unsigned XLEN = 32
) (
  input  logic            sysclk,
  input  logic            sysreset,
  input  logic [31:0]     inst,
  input  logic [XLEN-1:0] a_in,
  input  logic [XLEN-1:0] b_in,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic [XLEN-1:0] alu_result,
  output logic            brq,
  output logic            pc_sel,
  output logic            reg_we,
  output logic            a_sel,
  output logic            b_sel,
  output logic [2:0]      inst_type,
  output logic [3:0]      alu_op,
  output logic [2:0]      funct3,
  output logic            mem_we,
  output logic [1:0]      wb_sel,
  output logic            illegal,
  output logic            illegal_seen
);

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_SLL  = 4'd2,
    ALU_SLT  = 4'd3,
    ALU_SLTU = 4'd4,
    ALU_XOR  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_OR   = 4'd8,
    ALU_AND  = 4'd9
  } alu_op_e;

  typedef enum logic [2:0] {
    TYPE_R = 3'd0,
    TYPE_I = 3'd1,
    TYPE_S = 3'd2,
    TYPE_B = 3'd3,
    TYPE_U = 3'd4,
    TYPE_J = 3'd5
  } inst_type_e;

  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LOAD   = 7'b0000011,
    OPC_STORE  = 7'b0100011,
    OPC_BRANCH = 7'b1100011,
    OPC_JAL    = 7'b1101111,
    OPC_JALR   = 7'b1100111,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111
  } opcode_e;

  alu_op_e    arith_op;
  alu_op_e    op;
  inst_type_e itype;
  logic [4:0] shamt;
  logic       unused_inst_bits;

  // Fields outside opcode/funct3/bit30 belong to the external immediate
  // generator and register file.
  assign unused_inst_bits = ^{inst[31], inst[29:15], inst[11:7]};

  assign funct3    = inst[14:12];
  assign alu_op    = op;
  assign inst_type = itype;
  assign shamt     = b_in[4:0];

  // funct3 -> ALU op for R-type and OP-IMM. inst[30] picks SUB only for
  // R-type (ADDI carries immediate bits there) and SRA/SRAI for both.
  always_comb begin
    arith_op = ALU_ADD;
    case (funct3)
      3'b000:  arith_op = (inst[6:0] == OPC_OP && inst[30]) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = inst[30] ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end

  // Main decoder
  always_comb begin
    pc_sel  = 1'b0;
    reg_we  = 1'b0;
    mem_we  = 1'b0;
    wb_sel  = 2'b00;
    a_sel   = 1'b1;
    b_sel   = 1'b1;
    op      = ALU_ADD;
    itype   = TYPE_I;
    illegal = 1'b0;
    case (inst[6:0])
      OPC_OP: begin
        reg_we = 1'b1;
        b_sel  = 1'b0;
        op     = arith_op;
        itype  = TYPE_R;
      end
      OPC_OP_IMM: begin
        reg_we = 1'b1;
        op     = arith_op;
      end
      OPC_LOAD: begin
        reg_we = 1'b1;
        wb_sel = 2'b01;
      end
      OPC_STORE: begin
        mem_we = 1'b1;
        itype  = TYPE_S;
      end
      OPC_BRANCH: begin
        a_sel  = 1'b0;
        itype  = TYPE_B;
        pc_sel = brq;
      end
      OPC_JAL: begin
        reg_we = 1'b1;
        a_sel  = 1'b0;
        pc_sel = 1'b1;
        wb_sel = 2'b10;
        itype  = TYPE_J;
      end
      OPC_JALR: begin
        reg_we = 1'b1;
        pc_sel = 1'b1;
        wb_sel = 2'b10;
      end
      OPC_LUI: begin
        reg_we = 1'b1;
        a_sel  = 1'b0;
        wb_sel = 2'b11;
        itype  = TYPE_U;
      end
      OPC_AUIPC: begin
        reg_we = 1'b1;
        a_sel  = 1'b0;
        itype  = TYPE_U;
      end
      default: begin
        illegal = 1'b1;
        b_sel   = 1'b0;
      end
    endcase
  end

  // ALU; unused codes 10-15 fall back to ADD
  always_comb begin
    alu_result = '0;
    case (alu_op)
      ALU_SUB:  alu_result = a_in - b_in;
      ALU_SLL:  alu_result = a_in << shamt;
      ALU_SLT:  alu_result = {{(XLEN-1){1'b0}}, ($signed(a_in) < $signed(b_in))};
      ALU_SLTU: alu_result = {{(XLEN-1){1'b0}}, (a_in < b_in)};
      ALU_XOR:  alu_result = a_in ^ b_in;
      ALU_SRL:  alu_result = a_in >> shamt;
      ALU_SRA:  alu_result = $signed(a_in) >>> shamt;
      ALU_OR:   alu_result = a_in | b_in;
      ALU_AND:  alu_result = a_in & b_in;
      default:  alu_result = a_in + b_in;
    endcase
  end

  // Branch comparator
  always_comb begin
    brq = 1'b0;
    case (funct3)
      3'b000:  brq = (rs1 == rs2);
      3'b001:  brq = (rs1 != rs2);
      3'b100:  brq = ($signed(rs1) < $signed(rs2));
      3'b101:  brq = ($signed(rs1) >= $signed(rs2));
      3'b110:  brq = (rs1 < rs2);
      3'b111:  brq = (rs1 >= rs2);
      default: brq = 1'b0;
    endcase
  end

  always_ff @(posedge sysclk or posedge sysreset) begin
    if (sysreset)
      illegal_seen <= 1'b0;
    else if (illegal)
      illegal_seen <= 1'b1;
  end

endmodule

// File: tb/tb_rv32i_decode_execute.sv
module tb_rv32i_decode_execute;

  logic        sysclk;
  logic        sysreset;
  logic [31:0] inst, a_in, b_in, rs1, rs2;
  logic [31:0] alu_result;
  logic        brq, pc_sel, reg_we, a_sel, b_sel, mem_we, illegal, illegal_seen;
  logic [2:0]  inst_type, funct3;
  logic [3:0]  alu_op;
  logic [1:0]  wb_sel;

  int tests_run;
  int tests_failed;

  rv32i_decode_execute #(.XLEN(32)) dut (
    .sysclk       (sysclk),
    .sysreset     (sysreset),
    .inst         (inst),
    .a_in         (a_in),
    .b_in         (b_in),
    .rs1          (rs1),
    .rs2          (rs2),
    .alu_result   (alu_result),
    .brq          (brq),
    .pc_sel       (pc_sel),
    .reg_we       (reg_we),
    .a_sel        (a_sel),
    .b_sel        (b_sel),
    .inst_type    (inst_type),
    .alu_op       (alu_op),
    .funct3       (funct3),
    .mem_we       (mem_we),
    .wb_sel       (wb_sel),
    .illegal      (illegal),
    .illegal_seen (illegal_seen)
  );

  initial sysclk = 1'b0;
  always #5 sysclk = ~sysclk;

  typedef struct {
    logic [31:0] alu;
    logic        brq, pc_sel, reg_we, a_sel, b_sel, mem_we, illegal;
    logic [2:0]  typ, f3;
    logic [3:0]  op;
    logic [1:0]  wb;
  } exp_t;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Reference ALU: plain integer arithmetic on 64-bit values.
  function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint ua, ub, sa, p, q, r;
    ua = longint'(a);
    ub = longint'(b);
    sa = longint'(int'(a));
    p  = longint'(1) << b[4:0];
    case (op)
      4'd1: r = ua + 64'h1_0000_0000 - ub;
      4'd2: r = ua * p;
      4'd3: r = (int'(a) < int'(b)) ? 1 : 0;
      4'd4: r = (ua < ub) ? 1 : 0;
      4'd5: r = longint'(a ^ b);
      4'd6: r = ua / p;
      4'd7: begin
        q = sa / p;
        if (sa < 0 && (sa % p) != 0) q = q - 1;
        r = q;
      end
      4'd8: r = longint'(a | b);
      4'd9: r = longint'(a & b);
      default: r = ua + ub;
    endcase
    return r[31:0];
  endfunction

  function automatic exp_t model(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] r1, input logic [31:0] r2);
    exp_t e;
    logic [3:0] f3_op [8];
    logic [3:0] op_from_f3;
    logic [2:0] f3;
    f3_op = '{4'd0, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6, 4'd8, 4'd9};
    f3 = i[14:12];
    op_from_f3 = f3_op[f3];
    if (f3 == 3'd5 && i[30]) op_from_f3 = 4'd7;

    case (f3)
      3'd0: e.brq = (r1 == r2);
      3'd1: e.brq = (r1 != r2);
      3'd4: e.brq = (int'(r1) < int'(r2));
      3'd5: e.brq = !(int'(r1) < int'(r2));
      3'd6: e.brq = (r1 < r2);
      3'd7: e.brq = !(r1 < r2);
      default: e.brq = 1'b0;
    endcase

    e.f3 = f3;
    e.pc_sel = 0; e.reg_we = 0; e.mem_we = 0; e.wb = 2'b00; e.illegal = 0;
    e.a_sel = 1; e.b_sel = 1; e.op = 4'd0; e.typ = 3'd1;
    case (i[6:0])
      7'b0110011: begin
        e.reg_we = 1; e.b_sel = 0; e.typ = 3'd0;
        e.op = (f3 == 3'd0 && i[30]) ? 4'd1 : op_from_f3;
      end
      7'b0010011: begin e.reg_we = 1; e.op = op_from_f3; end
      7'b0000011: begin e.reg_we = 1; e.wb = 2'b01; end
      7'b0100011: begin e.mem_we = 1; e.typ = 3'd2; end
      7'b1100011: begin e.a_sel = 0; e.typ = 3'd3; e.pc_sel = e.brq; end
      7'b1101111: begin e.reg_we = 1; e.a_sel = 0; e.pc_sel = 1; e.wb = 2'b10; e.typ = 3'd5; end
      7'b1100111: begin e.reg_we = 1; e.pc_sel = 1; e.wb = 2'b10; end
      7'b0110111: begin e.reg_we = 1; e.a_sel = 0; e.wb = 2'b11; e.typ = 3'd4; end
      7'b0010111: begin e.reg_we = 1; e.a_sel = 0; e.typ = 3'd4; end
      default:    begin e.illegal = 1; e.b_sel = 0; end
    endcase
    e.alu = ref_alu(e.op, a, b);
    return e;
  endfunction

  task automatic apply(input logic [31:0] i, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r1, input logic [31:0] r2);
    inst = i; a_in = a; b_in = b; rs1 = r1; rs2 = r2;
    #1;
  endtask

  initial begin
    logic [6:0] legal_ops [9];
    exp_t e;
    logic [31:0] ri, ra, rb, r1, r2;
    tests_run = 0;
    tests_failed = 0;
    legal_ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                  7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};

    // Sticky illegal flag
    sysreset = 1'b1;
    inst = 32'h0; a_in = '0; b_in = '0; rs1 = '0; rs2 = '0;
    @(posedge sysclk); #1;
    @(posedge sysclk); #1;
    check("seen_held_in_reset", illegal_seen, 32'd0);
    @(negedge sysclk);
    sysreset = 1'b0;
    inst = 32'h00A00093;
    @(posedge sysclk); #1;
    check("seen_after_legal", illegal_seen, 32'd0);
    @(negedge sysclk);
    inst = 32'h00000000;
    #1;
    check("illegal_comb", illegal, 32'd1);
    check("seen_before_edge", illegal_seen, 32'd0);
    @(posedge sysclk); #1;
    check("seen_set", illegal_seen, 32'd1);
    @(negedge sysclk);
    inst = 32'h00A00093;
    @(posedge sysclk); #1;
    check("seen_sticky", illegal_seen, 32'd1);
    #2 sysreset = 1'b1;
    #1;
    check("seen_async_clear", illegal_seen, 32'd0);
    @(negedge sysclk);
    sysreset = 1'b0;

    // Directed cases
    apply(32'h00A00093, 32'd0, 32'd10, '0, '0);
    check("addi_reg_we", reg_we, 1); check("addi_a_sel", a_sel, 1);
    check("addi_b_sel", b_sel, 1);   check("addi_alu_op", alu_op, 0);
    check("addi_wb_sel", wb_sel, 0); check("addi_type", inst_type, 1);
    check("addi_mem_we", mem_we, 0); check("addi_alu", alu_result, 32'h0000000A);

    apply(32'h000082A3, 32'd10, 32'd5, '0, '0);
    check("sb_mem_we", mem_we, 1); check("sb_reg_we", reg_we, 0);
    check("sb_type", inst_type, 2); check("sb_funct3", funct3, 0);
    check("sb_alu", alu_result, 32'd15); check("sb_pc_sel", pc_sel, 0);

    apply(32'h002081B3, 32'd10, 32'hFFFFFFF6, '0, '0);
    check("add_wrap", alu_result, 32'h0);
    apply(32'h402081B3, 32'd5, 32'd7, '0, '0);
    check("sub_neg", alu_result, 32'hFFFFFFFE);
    apply(32'h4020D1B3, 32'h80000000, 32'd4, '0, '0);
    check("sra", alu_result, 32'hF8000000);
    apply(32'h0020D1B3, 32'h80000000, 32'd4, '0, '0);
    check("srl", alu_result, 32'h08000000);

    apply(32'h00000063, '0, '0, 32'd7, 32'd7);
    check("beq_brq", brq, 1); check("beq_pc_sel", pc_sel, 1); check("beq_a_sel", a_sel, 0);
    apply(32'h00000063, '0, '0, 32'd7, 32'd8);
    check("beq_ne_pc_sel", pc_sel, 0);
    apply(32'h00004063, '0, '0, 32'hFFFFFFFF, 32'd1);
    check("blt_brq", brq, 1);
    apply(32'h00006063, '0, '0, 32'hFFFFFFFF, 32'd1);
    check("bltu_brq", brq, 0);
    apply(32'h00002063, '0, '0, 32'd3, 32'd3);
    check("funct3_010_brq", brq, 0);

    apply(32'h008000EF, '0, '0, '0, '0);
    check("jal_pc_sel", pc_sel, 1); check("jal_reg_we", reg_we, 1);
    check("jal_wb_sel", wb_sel, 2); check("jal_type", inst_type, 5);
    check("jal_a_sel", a_sel, 0);   check("jal_b_sel", b_sel, 1);

    apply(32'h00000000, '0, '0, '0, '0);
    check("ill_flag", illegal, 1); check("ill_reg_we", reg_we, 0);
    check("ill_mem_we", mem_we, 0); check("ill_pc_sel", pc_sel, 0);

    // Randomized against the reference model
    for (int n = 0; n < 400; n++) begin
      ri = $urandom;
      if ($urandom_range(7) != 0) ri[6:0] = legal_ops[$urandom_range(8)];
      ra = $urandom;
      rb = $urandom;
      r1 = $urandom;
      r2 = ($urandom_range(3) == 0) ? r1 : $urandom;
      if ($urandom_range(3) == 0) r2 = {r1[31], r2[30:0]};
      apply(ri, ra, rb, r1, r2);
      e = model(ri, ra, rb, r1, r2);
      check("rnd_alu", alu_result, e.alu);
      check("rnd_brq", brq, e.brq);
      check("rnd_pc_sel", pc_sel, e.pc_sel);
      check("rnd_reg_we", reg_we, e.reg_we);
      check("rnd_a_sel", a_sel, e.a_sel);
      check("rnd_b_sel", b_sel, e.b_sel);
      check("rnd_type", inst_type, e.typ);
      check("rnd_alu_op", alu_op, e.op);
      check("rnd_funct3", funct3, e.f3);
      check("rnd_mem_we", mem_we, e.mem_we);
      check("rnd_wb_sel", wb_sel, e.wb);
      check("rnd_illegal", illegal, e.illegal);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/rv32i_decode_execute.md
Name: rv32i_decode_execute

Overview:
Combinational decode and execute slice of the single-cycle RV32I core. It bundles the control unit (main decoder), the ALU and the branch comparator. From the current instruction it produces every datapath control signal, computes the ALU result and resolves branch conditions. Operand muxes, register file, immediate generator, PC, write-back mux and load unit are external. One small clocked register latches a sticky illegal-instruction flag.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
sysclk  in  1  clock; only the sticky flag register uses it.
sysreset  in  1  asynchronous, active-high reset.
inst  in  32  current instruction.
a_in  in  32  ALU operand A, driven by the external A mux (pc_curr or rs1).
b_in  in  32  ALU operand B, driven by the external B mux (rs2 or imm_x).
rs1  in  32  register operand for branch compare.
rs2  in  32  register operand for branch compare.
alu_result  out  32  ALU output.
brq  out  1  branch condition true.
pc_sel  out  1  0 = pc+4, 1 = alu_result.
reg_we  out  1  register-file write enable.
a_sel  out  1  0 = pc_curr, 1 = rs1.
b_sel  out  1  0 = rs2, 1 = imm_x.
inst_type  out  3  immediate format: 0=R, 1=I, 2=S, 3=B, 4=U, 5=J.
alu_op  out  4  0 ADD, 1 SUB, 2 SLL, 3 SLT, 4 SLTU, 5 XOR, 6 SRL, 7 SRA, 8 OR, 9 AND.
funct3  out  3  inst[14:12], passed through.
mem_we  out  1  data-memory byte write enable.
wb_sel  out  2  00 alu_result, 01 load data, 10 pc_next, 11 imm_x.
illegal  out  1  combinational: opcode is not supported.
illegal_seen  out  1  sticky registered illegal flag.

Behaviour:
- All outputs except illegal_seen are purely combinational, zero latency, and do not depend on sysclk or sysreset.
- ALU, by alu_op:
  - ADD/SUB: wrap modulo 2^32.
  - SLL/SRL/SRA: shift amount is b_in[4:0].
  - SLT (signed) and SLTU (unsigned): result 1 or 0.
  - Codes 10-15: result = a_in + b_in.
- Branch compare, on rs1/rs2, by funct3:
  - 000 EQ, 001 NE, 100 signed LT, 101 signed GE, 110 unsigned LT, 111 unsigned GE.
  - 010 and 011 give brq = 0.
  - brq is computed for every instruction.
- Decode, by opcode inst[6:0]:
  - 0110011 R: reg_we=1, a_sel=1, b_sel=0, wb=00, type R. alu_op from funct3; inst[30] selects SUB for funct3 000 and SRA for funct3 101.
  - 0010011 OP-IMM: reg_we=1, a_sel=1, b_sel=1, wb=00, type I. alu_op from funct3; inst[30] is used only for funct3 101 (SRAI). ADDI ignores inst[30].
  - 0000011 LOAD: reg_we=1, a_sel=1, b_sel=1, ADD, wb=01, type I.
  - 0100011 STORE: mem_we=1, reg_we=0, a_sel=1, b_sel=1, ADD, type S.
  - 1100011 BRANCH: a_sel=0, b_sel=1, ADD, type B, pc_sel=brq, reg_we=0.
  - 1101111 JAL: reg_we=1, a_sel=0, b_sel=1, ADD, pc_sel=1, wb=10, type J.
  - 1100111 JALR: reg_we=1, a_sel=1, b_sel=1, ADD, pc_sel=1, wb=10, type I. alu_result is not LSB-cleared here.
  - 0110111 LUI: reg_we=1, a_sel=0, b_sel=1, ADD, wb=11, type U.
  - 0010111 AUIPC: reg_we=1, a_sel=0, b_sel=1, ADD, wb=00, type U.
- Defaults, for pc_sel, mem_we, reg_we and wb_sel whenever the opcode does not set them: pc_sel=0, mem_we=0, reg_we=0, wb_sel=00.
- Any other opcode:
  - illegal=1.
  - reg_we=0, mem_we=0, pc_sel=0.
  - a_sel=1, b_sel=0, alu_op=ADD, type I, wb=00.
- reg_we is asserted even when rd = x0; the register file suppresses the write.
- mem_we and reg_we are never both 1.
- illegal_seen register:
  - Asynchronous clear to 0 on sysreset=1, including a reset asserted mid-cycle.
  - Set on a rising sysclk edge when illegal=1; otherwise holds.
  - Stays 0 while sysreset is high.

Test Plan:
- ADDI, inst=00A00093, a_in=0, b_in=10 -> reg_we=1, a_sel=1, b_sel=1, alu_op=0, wb_sel=00, inst_type=1, mem_we=0, alu_result=0x0000000A.
- SB, inst=000082A3, a_in=10, b_in=5 -> mem_we=1, reg_we=0, inst_type=2, funct3=000, alu_result=15, pc_sel=0.
- R-type ALU results:
  - ADD, inst=002081B3, a_in=10, b_in=0xFFFFFFF6 -> alu_result=0.
  - SUB, inst=402081B3, a_in=5, b_in=7 -> alu_result=0xFFFFFFFE.
  - SRA, a_in=0x80000000, b_in=4 -> 0xF8000000; SRL with the same operands -> 0x08000000.
- Branches:
  - BEQ, rs1=rs2=7 -> brq=1, pc_sel=1, a_sel=0. Same with rs2=8 -> pc_sel=0.
  - BLT, rs1=0xFFFFFFFF, rs2=1 -> brq=1; BLTU with the same operands -> brq=0.
- JAL, inst=008000EF -> pc_sel=1, reg_we=1, wb_sel=10, inst_type=5, a_sel=0, b_sel=1.
- Illegal opcode, inst=00000000 -> illegal=1, all enables 0. illegal_seen rises at the next sysclk edge; asserting sysreset mid-cycle clears it immediately.
